// File: rtl/cla_sub_pipe.sv
// Two-stage pipelined carry-lookahead subtractor: diff = a - b - bin.
// Low half resolves in stage 1, high half in stage 2 from the registered carry.
module cla_sub_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic [WIDTH:0]   out
);

  localparam int HALF = WIDTH / 2;

  // Sum of x + y + cin using 4-bit groups; each bit carry is a sum of products
  // inside its group, seeded by the group carry-in from the previous group.
  function automatic logic [HALF:0] claHalf(input logic [HALF-1:0] x,
                                            input logic [HALF-1:0] y,
                                            input logic            cin);
    logic [HALF-1:0] g;
    logic [HALF-1:0] p;
    logic [HALF:0]   c;
    logic            term;
    logic            prop;
    int              gs;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = cin;
    for (int n = 0; n < HALF; n++) begin
      gs   = (n / 4) * 4;
      term = 1'b0;
      prop = 1'b1;
      for (int i = n; i >= gs; i--) begin
        term = term | (g[i] & prop);
        prop = prop & p[i];
      end
      c[n+1] = term | (prop & c[gs]);
    end
    return {c[HALF], p ^ c[HALF-1:0]};
  endfunction

  logic            r_s1_valid;
  logic [HALF-1:0] r_s1_lo;
  logic            r_s1_carry;
  logic [HALF-1:0] r_s1_ahi;
  logic [HALF-1:0] r_s1_bhi;

  logic             r_s2_valid;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_ovf;

  logic [HALF:0] w_lo;
  logic [HALF:0] w_hi;
  logic          w_s1_load;
  logic          w_s2_load;
  logic          w_ovf;

  // Subtraction as a + ~b + ~bin; borrow is the inverted carry-out.
  assign w_lo = claHalf(a[HALF-1:0], ~b[HALF-1:0], ~bin);
  assign w_hi = claHalf(r_s1_ahi, ~r_s1_bhi, r_s1_carry);

  assign w_ovf = (r_s1_ahi[HALF-1] != r_s1_bhi[HALF-1]) &&
                 (w_hi[HALF-1] != r_s1_ahi[HALF-1]);

  assign in_ready  = !r_s1_valid || !r_s2_valid || out_ready;
  assign w_s1_load = in_valid && in_ready;
  assign w_s2_load = r_s1_valid && (!r_s2_valid || out_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_lo    <= '0;
      r_s1_carry <= 1'b0;
      r_s1_ahi   <= '0;
      r_s1_bhi   <= '0;
    end else begin
      if (w_s1_load) begin
        r_s1_valid <= 1'b1;
        r_s1_lo    <= w_lo[HALF-1:0];
        r_s1_carry <= w_lo[HALF];
        r_s1_ahi   <= a[WIDTH-1:HALF];
        r_s1_bhi   <= b[WIDTH-1:HALF];
      end else if (w_s2_load) begin
        r_s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_diff     <= '0;
      r_bout     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_s2_load) begin
        r_s2_valid <= 1'b1;
        r_diff     <= {w_hi[HALF-1:0], r_s1_lo};
        r_bout     <= ~w_hi[HALF];
        r_ovf      <= w_ovf;
      end else if (out_ready) begin
        r_s2_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign diff      = r_diff;
  assign bout      = r_bout;
  assign ovf       = r_ovf;
  assign out       = {r_bout, r_diff};

endmodule
